// File: rtl/fighter_pkg.sv
// Shared types and frame-count helpers for the fighter animation sequencer.
// Purely declarative: no logic, no latency, no flow control.
package fighter_pkg;

  typedef enum logic [7:0] {
    ST_STAND  = 8'd0,
    ST_ATTACK = 8'd1,
    ST_MOVEL  = 8'd2,
    ST_MOVER  = 8'd3,
    ST_HURT   = 8'd4,
    ST_DEFEND = 8'd5
  } anim_state_t;

  localparam int STAND_FRAMES_DEF  = 8;
  localparam int ATTACK_FRAMES_DEF = 9;
  localparam int MOVE_FRAMES_DEF   = 5;
  localparam int HURT_FRAMES_DEF   = 4;
  localparam int DEFEND_FRAMES     = 1;

  // Length of the loop or one-shot played in a state; unknown codes get 1 so
  // the sequencer treats them as "last frame" and recovers on the next tick.
  function automatic logic [7:0] frames_for(
    input anim_state_t s,
    input int stand_n  = STAND_FRAMES_DEF,
    input int attack_n = ATTACK_FRAMES_DEF,
    input int move_n   = MOVE_FRAMES_DEF,
    input int hurt_n   = HURT_FRAMES_DEF
  );
    case (s)
      ST_STAND:           frames_for = 8'(stand_n);
      ST_ATTACK:          frames_for = 8'(attack_n);
      ST_MOVEL, ST_MOVER: frames_for = 8'(move_n);
      ST_HURT:            frames_for = 8'(hurt_n);
      ST_DEFEND:          frames_for = 8'(DEFEND_FRAMES);
      default:            frames_for = 8'd1;
    endcase
  endfunction

endpackage

// File: rtl/fighter_anim_ctrl_if.sv
// Key/hit inputs and animation outputs of one fighter sequencer.
// Level and strobe signals only; no handshake, the consumer never stalls.
interface fighter_anim_ctrl_if;

  logic       key_left;
  logic       key_right;
  logic       key_attack;
  logic       key_defend;
  logic       hit_in;
  logic [7:0] anim_state;
  logic [7:0] frame_num;
  logic       move_l;
  logic       move_r;
  logic       hurt;
  logic       attack_hit;
  logic       blocked;

  modport master (
    output key_left, key_right, key_attack, key_defend, hit_in,
    input  anim_state, frame_num, move_l, move_r, hurt, attack_hit, blocked
  );

  modport slave (
    input  key_left, key_right, key_attack, key_defend, hit_in,
    output anim_state, frame_num, move_l, move_r, hurt, attack_hit, blocked
  );

endinterface

// File: rtl/fighter_anim_ctrl_frame_tick_gen.sv
// Synchronises frame_clk into Clk, detects rising edges and divides them down
// to one-Clk tick pulses; tick fires 2 Clk after the synchronised edge lands, no backpressure.
module frame_tick_gen #(
  parameter int TICKS_PER_FRAME = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  localparam int CW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICKS_PER_FRAME - 1);

  logic          sync1;
  logic          sync2;
  logic          sync3;
  logic          edge_det;
  logic [CW-1:0] div_cnt;

  assign edge_det = sync2 & ~sync3;
  assign tick     = edge_det && (div_cnt == TERM);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
      div_cnt <= '0;
    end else begin
      sync1 <= frame_clk;
      sync2 <= sync1;
      sync3 <= sync2;
      if (edge_det) begin
        div_cnt <= (div_cnt == TERM) ? '0 : div_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fighter_anim_ctrl.sv
// Per-fighter animation sequencer: keys/hits -> state code, sprite frame, strobes.
// Outputs registered, updated the Clk after each frame tick; no backpressure. ATTACK_QUEUE_EN adds a one-deep attack queue.
module fighter_anim_ctrl
  import fighter_pkg::*;
#(
  parameter int TICKS_PER_FRAME  = 4,
  parameter int STAND_FRAMES     = 8,
  parameter int ATTACK_FRAMES    = 9,
  parameter int MOVE_FRAMES      = 5,
  parameter int HURT_FRAMES      = 4,
  parameter int ATTACK_HIT_FRAME = 5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  fighter_anim_ctrl_if.slave   bus
);

  logic        tick;
  anim_state_t state_q;
  anim_state_t state_d;
  anim_state_t key_pick;
  logic [7:0]  frame_q;
  logic [7:0]  frame_d;
  logic [7:0]  cur_len;
  logic        last;
  logic        restart;
  logic        hit_pending;
  logic        hit_now;
  logic        blocked_d;
  logic        atk_queued;
  logic        move_l_q;
  logic        move_r_q;
  logic        hurt_q;
  logic        attack_hit_q;
  logic        blocked_q;

  frame_tick_gen #(
    .TICKS_PER_FRAME (TICKS_PER_FRAME)
  ) u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  assign cur_len = frames_for(state_q, STAND_FRAMES, ATTACK_FRAMES, MOVE_FRAMES, HURT_FRAMES);
  assign last    = (frame_q >= cur_len - 8'd1);
  // A hit arriving on the tick cycle itself is consumed together with the pending one.
  assign hit_now = hit_pending | bus.hit_in;

  always_comb begin
    key_pick = ST_STAND;
    if (bus.key_attack) begin
      key_pick = ST_ATTACK;
    end else if (bus.key_defend) begin
      key_pick = ST_DEFEND;
    end else if (bus.key_right && !bus.key_left) begin
      key_pick = ST_MOVER;
    end else if (bus.key_left && !bus.key_right) begin
      key_pick = ST_MOVEL;
    end
  end

  always_comb begin
    state_d   = state_q;
    restart   = 1'b0;
    blocked_d = 1'b0;
    frame_d   = '0;
    case (state_q)
      ST_ATTACK: begin
        if (hit_now) begin
          state_d = ST_HURT;
        end else if (last) begin
          restart = 1'b1;
          state_d = atk_queued ? ST_ATTACK : key_pick;
        end
      end
      ST_HURT: begin
        if (last) begin
          restart = 1'b1;
          state_d = key_pick;
        end
      end
      ST_STAND, ST_MOVEL, ST_MOVER, ST_DEFEND: begin
        if (hit_now) begin
          if (state_q == ST_DEFEND) begin
            blocked_d = 1'b1;
          end else begin
            state_d = ST_HURT;
          end
        end else begin
          state_d = key_pick;
        end
      end
      default: state_d = ST_STAND;
    endcase
    // One-shots replay from frame 0 even when the same state is re-entered.
    if (state_d != state_q || restart || last) begin
      frame_d = '0;
    end else begin
      frame_d = frame_q + 8'd1;
    end
  end

`ifdef ATTACK_QUEUE_EN
  logic atk_key_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      atk_queued <= 1'b0;
      atk_key_d  <= 1'b0;
    end else begin
      atk_key_d <= bus.key_attack;
      if (tick && (state_d == ST_HURT || (state_q == ST_ATTACK && last))) begin
        atk_queued <= 1'b0;
      end else if (bus.key_attack && !atk_key_d && state_q == ST_ATTACK &&
                   frame_q >= 8'(ATTACK_HIT_FRAME)) begin
        atk_queued <= 1'b1;
      end
    end
  end
`else
  assign atk_queued = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_STAND;
      frame_q      <= '0;
      hit_pending  <= 1'b0;
      move_l_q     <= 1'b0;
      move_r_q     <= 1'b0;
      hurt_q       <= 1'b0;
      attack_hit_q <= 1'b0;
      blocked_q    <= 1'b0;
    end else begin
      attack_hit_q <= 1'b0;
      blocked_q    <= 1'b0;
      if (tick) begin
        hit_pending  <= 1'b0;
        state_q      <= state_d;
        frame_q      <= frame_d;
        move_l_q     <= (state_d == ST_MOVEL);
        move_r_q     <= (state_d == ST_MOVER);
        hurt_q       <= (state_d == ST_HURT);
        attack_hit_q <= (state_d == ST_ATTACK) && (frame_d == 8'(ATTACK_HIT_FRAME));
        blocked_q    <= blocked_d;
      end else if (bus.hit_in) begin
        hit_pending <= 1'b1;
      end
    end
  end

  assign bus.anim_state = state_q;
  assign bus.frame_num  = frame_q;
  assign bus.move_l     = move_l_q;
  assign bus.move_r     = move_r_q;
  assign bus.hurt       = hurt_q;
  assign bus.attack_hit = attack_hit_q;
  assign bus.blocked    = blocked_q;

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Directed bench for fighter_anim_ctrl with a tick-level behavioural model
// checked every settled cycle, plus hand-computed checkpoints.
module tb_fighter_anim_ctrl;

  localparam int TPF = 4;

  logic Clk       = 1'b0;
  logic Reset     = 1'b1;
  logic frame_clk = 1'b0;

  fighter_anim_ctrl_if bus ();

  fighter_anim_ctrl #(.TICKS_PER_FRAME(TPF)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  always #10 Clk = ~Clk;

  int n_checks   = 0;
  int n_fail     = 0;
  int m_state    = 0;
  int m_frame    = 0;
  int m_div      = 0;
  bit m_hit      = 0;
  bit m_queue    = 0;
  bit exp_ahit   = 0;
  bit exp_blk    = 0;
  int ahit_cnt   = 0;
  int blk_cnt    = 0;
  int ahit_total = 0;
  int blk_total  = 0;
  bit settled    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_len(input int s);
    case (s)
      0:       return 8;
      1:       return 9;
      2, 3:    return 5;
      4:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int m_pick();
    if (bus.key_attack) return 1;
    if (bus.key_defend) return 5;
    if (bus.key_right && !bus.key_left) return 3;
    if (bus.key_left && !bus.key_right) return 2;
    return 0;
  endfunction

  // Advances the model by one frame_clk edge; every TPF-th edge is a tick.
  task automatic model_edge();
    int ns;
    bit done;
    exp_ahit = 0;
    exp_blk  = 0;
    m_div++;
    if (m_div < TPF) return;
    m_div = 0;
    done = (m_state == 1 || m_state == 4) && (m_frame == m_len(m_state) - 1);
    if (m_state == 4) ns = done ? m_pick() : 4;
    else if (m_hit) begin
      ns      = (m_state == 5) ? 5 : 4;
      exp_blk = (m_state == 5);
    end
    else if (m_state == 1 && !done) ns = 1;
    else if (m_state == 1 && m_queue) ns = 1;
    else ns = m_pick();
    if ((m_state == 1 && done) || ns == 4) m_queue = 0;
    m_hit   = 0;
    m_frame = (ns != m_state || done) ? 0 : (m_frame + 1) % m_len(m_state);
    m_state = ns;
    exp_ahit = (ns == 1 && m_frame == 5);
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.attack_hit === 1'b1) begin ahit_cnt++; ahit_total++; end
      if (bus.blocked === 1'b1) begin blk_cnt++; blk_total++; end
      if (settled) begin
        chk("anim_state", bus.anim_state, m_state);
        chk("frame_num", bus.frame_num, m_frame);
        chk("move_l", bus.move_l, m_state == 2);
        chk("move_r", bus.move_r, m_state == 3);
        chk("hurt", bus.hurt, m_state == 4);
        chk("attack_hit_idle", bus.attack_hit, 0);
        chk("blocked_idle", bus.blocked, 0);
      end
    end
  end

  task automatic frame_edge();
    @(negedge Clk);
    settled   = 0;
    ahit_cnt  = 0;
    blk_cnt   = 0;
    frame_clk = 1'b1;
    model_edge();
    repeat (6) @(negedge Clk);
    chk("attack_hit_count", ahit_cnt, exp_ahit);
    chk("blocked_count", blk_cnt, exp_blk);
    settled   = 1;
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic ticks(input int n);
    repeat (n * TPF) frame_edge();
  endtask

  task automatic set_attack(input bit v);
    @(negedge Clk);
`ifdef ATTACK_QUEUE_EN
    if (v && !bus.key_attack && m_state == 1 && m_frame >= 5) m_queue = 1;
`endif
    bus.key_attack = v;
  endtask

  task automatic pulse_hit();
    @(negedge Clk);
    bus.hit_in = 1'b1;
    m_hit      = 1;
    @(negedge Clk);
    bus.hit_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset   = 1'b1;
    settled = 0;
    m_state = 0; m_frame = 0; m_div = 0; m_hit = 0; m_queue = 0;
    @(negedge Clk);
    chk("reset_state", bus.anim_state, 0);
    chk("reset_frame", bus.frame_num, 0);
    chk("reset_levels", {bus.move_l, bus.move_r, bus.hurt, bus.attack_hit, bus.blocked}, 0);
    Reset   = 1'b0;
    settled = 1;
  endtask

  initial begin
    bus.key_left   = 1'b0;
    bus.key_right  = 1'b0;
    bus.key_attack = 1'b0;
    bus.key_defend = 1'b0;
    bus.hit_in     = 1'b0;
    do_reset();

    // Idle: 40 edges give 10 ticks of the 8-frame stand loop.
    ticks(10);
    chk("idle_state", bus.anim_state, 0);
    chk("idle_frame", bus.frame_num, 2);

    bus.key_right = 1'b1;
    ticks(1);
    chk("mover_state", bus.anim_state, 3);
    chk("mover_level", bus.move_r, 1);
    chk("mover_entry_frame", bus.frame_num, 0);
    ticks(5);
    chk("mover_wrap", bus.frame_num, 0);
    bus.key_right = 1'b0;
    ticks(1);
    chk("release_stand", bus.anim_state, 0);
    chk("release_frame", bus.frame_num, 0);

    ahit_total = 0;
    set_attack(1);
    ticks(1);
    chk("attack_entry", bus.anim_state, 1);
    set_attack(0);
    ticks(8);
    chk("attack_last_frame", bus.frame_num, 8);
    chk("attack_hit_once", ahit_total, 1);
    ticks(1);
    chk("attack_done", bus.anim_state, 0);

    bus.key_right = 1'b1;
    ticks(1);
    pulse_hit();
    bus.key_right = 1'b0;
    ticks(1);
    chk("hurt_entry", bus.anim_state, 4);
    chk("hurt_level", bus.hurt, 1);
    pulse_hit();
    ticks(3);
    chk("hurt_last_frame", bus.frame_num, 3);
    ticks(1);
    chk("hurt_done", bus.anim_state, 0);
    chk("hurt_cleared", bus.hurt, 0);
    ticks(1);
    chk("hit_in_hurt_dropped", bus.anim_state, 0);

    blk_total = 0;
    bus.key_defend = 1'b1;
    ticks(1);
    chk("defend_entry", bus.anim_state, 5);
    pulse_hit();
    ticks(1);
    chk("defend_hold", bus.anim_state, 5);
    chk("blocked_once", blk_total, 1);
    chk("defend_no_hurt", bus.hurt, 0);
    ticks(2);
    chk("blocked_still_once", blk_total, 1);
    bus.key_defend = 1'b0;
    ticks(1);

    bus.key_left = 1'b1;
    ticks(1);
    chk("movel_state", bus.anim_state, 2);
    bus.key_right = 1'b1;
    ticks(1);
    chk("both_dirs_stand", bus.anim_state, 0);
    chk("both_dirs_no_move", {bus.move_l, bus.move_r}, 0);
    bus.key_left  = 1'b0;
    bus.key_right = 1'b0;

    // Reset in mid-attack with a hit pending: the hit must not survive.
    set_attack(1);
    ticks(1);
    set_attack(0);
    ticks(3);
    pulse_hit();
    do_reset();
    ticks(1);
    chk("post_reset_state", bus.anim_state, 0);
    chk("post_reset_frame", bus.frame_num, 1);

    set_attack(1);
    ticks(1);
    set_attack(0);
    ticks(6);
    chk("repress_frame", bus.frame_num, 6);
    set_attack(1);
    set_attack(0);
    ticks(2);
    chk("chain_last_frame", bus.frame_num, 8);
    ticks(1);
`ifdef ATTACK_QUEUE_EN
    chk("queued_chain", bus.anim_state, 1);
`else
    chk("no_queue_stand", bus.anim_state, 0);
`endif
    ticks(9);
    chk("final_state", bus.anim_state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fighter_anim_ctrl.md
Name: fighter_anim_ctrl

Overview:
Per-character animation sequencer for the sprite rendering datapath. It turns keyboard intents and hit events into the character state code and sprite frame index that the sprite RAM address generator consumes. It also produces the move_r/move_l level signals for the position update logic and a one-cycle attack-hit strobe for the damage logic. There is one instance per fighter.

Parameters:
TICKS_PER_FRAME, 4, frame_clk rising edges per sprite frame advance (must be ≥1)
STAND_FRAMES, 8, stand loop length
ATTACK_FRAMES, 9, attack one-shot length
MOVE_FRAMES, 5, forward/backward loop length
HURT_FRAMES, 4, hurt one-shot length
ATTACK_HIT_FRAME, 5, attack frame at which attack_hit strobes

Ports:
Clk  in  1  50 MHz system clock
Reset  in  1  synchronous, active-high reset
frame_clk  in  1  ~60 Hz frame clock, asynchronous to Clk
key_left  in  1  left held
key_right  in  1  right held
key_attack  in  1  attack held
key_defend  in  1  defend held
hit_in  in  1  opponent landed a hit (pulse, any length)
anim_state  out  8  0=stand 1=attack 2=movel 3=mover 4=hurt 5=defend
frame_num  out  8  current sprite frame index
move_l  out  1  level: in movel state
move_r  out  1  level: in mover state
hurt  out  1  level: in hurt state
attack_hit  out  1  one-Clk strobe on entering ATTACK_HIT_FRAME
blocked  out  1  one-Clk strobe when a hit is absorbed by defend

Behaviour:
- Reset: anim_state=0 (stand), frame_num=0, every output 0, tick divider 0, hit_pending 0, edge synchroniser cleared.
- frame_clk passes through a 2-flop synchroniser and rising-edge detect, giving edge (1 Clk). The divider counts edges 0..TICKS_PER_FRAME-1. Tick = edge while the divider is at terminal count; the divider then wraps to 0.
- hit_in high on any Clk sets hit_pending. hit_pending clears when consumed at a tick. If the state is hurt at that tick, it is discarded.
- All state and frame updates happen only on tick. Outputs are registered and change the cycle after the tick.
- Next-state priority at tick in stand/movel/mover/defend:
  - hit_pending: if current=defend, stay defend and pulse blocked; otherwise go to hurt.
  - key_attack → attack.
  - key_defend → defend.
  - key_right & !key_left → mover.
  - key_left & !key_right → movel.
  - otherwise stand (both directions held = stand).
- attack: non-interruptible except by hit_pending→hurt. Plays frames 0..ATTACK_FRAMES-1 once. At the tick after the last frame, it re-evaluates priority (held key_attack re-enters attack at frame 0).
- hurt: plays 0..HURT_FRAMES-1 once. Keys and hits are ignored. At the tick after the last frame, it goes to stand, or applies priority if keys are held.
- Loop states: stand wraps at STAND_FRAMES-1, movel/mover at MOVE_FRAMES-1, defend holds frame 0.
- Any state change forces frame_num=0. Same-state ticks increment frame_num.
- attack_hit: single Clk pulse in the cycle frame_num becomes ATTACK_HIT_FRAME while in attack.
- frame_num is 8-bit and always below the state's frame count. Illegal state codes recover to stand/0 at the next tick.
- Reset mid-animation: immediate return to reset values on the next Clk. A pending hit is dropped.

Optional Feature:
ATTACK_QUEUE_EN.
- Defined: a rising edge of key_attack during attack frames ≥ ATTACK_HIT_FRAME sets a one-deep queue flag. At attack end, a set flag forces re-entry to attack even if the key has been released. The flag clears on use, on hurt entry, and on Reset.
- Undefined: no queue; only a held key_attack chains attacks.

Decomposition:
- Package fighter_pkg holds:
  - anim_state_t enum (8-bit, codes 0..5 as above).
  - Default frame-count constants.
  - A function frames_for(anim_state_t) returning the loop/one-shot length.
- Sub-module frame_tick_gen holds the synchroniser, edge detect and TICKS_PER_FRAME divider; its output is tick.

Test Plan:
- Reset, no keys, 40 frame_clk edges → 10 ticks; stand frames 0..7,0,1; all strobes 0.
- key_right held from tick 0 → anim_state=3 and move_r=1 after tick 1; frames 0..4 then wrap to 0; release → stand, frame 0 at next tick.
- key_attack pulsed for one tick → attack frames 0..8; exactly one attack_hit at frame 5; then stand.
- hit_in 1-cycle pulse during mover → hurt at next tick; hurt=1 for 4 ticks; a second hit_in during hurt is ignored; then stand.
- key_defend held plus hit_in → anim_state stays 5, blocked pulses once, hurt stays 0.
- key_left and key_right held together → stand. With ATTACK_QUEUE_EN, re-pressing attack at frame 6 chains a second attack without holding the key.
